msf_frame_assembler: RTL and testbench

- Consumes the per-second symbol stream from `decoder`: valid strobe, second-00 flag and 2-bit A/B data.
- Assembles one MSF minute frame, then applies the enabled checks: parity bits 54B–57B and the 53A–58A marker.
- On the next minute marker it commits the decoded BCD date/time to holding registers.
- A registered 8-bit display mux selects one field for io_out. This is the parametrised successor of the top-level datapath that currently ties io_out to zero.

---
 rtl/msf_frame_assembler.sv | 176 +++++++++++++++++
 tb/tb_msf_frame_assembler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msf_frame_assembler.sv
// MSF minute-frame assembler: collects per-second A/B symbols, checks the minute
// marker and odd-parity groups, and commits BCD date/time to holding registers.
module msf_frame_assembler #(
    parameter bit          PARITY_EN = 1'b1,
    parameter bit          MARKER_EN = 1'b1,
    parameter int unsigned MAX_SEC   = 60,
    parameter int unsigned MIN_SEC   = 58
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bits_valid_i,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
    input  logic [2:0] disp_sel_i,
    output logic       time_valid_o,
    output logic       synced_o,
    output logic       frame_err_o,
    output logic [5:0] second_o,
    output logic [7:0] year_o,
    output logic [4:0] month_o,
    output logic [5:0] day_o,
    output logic [2:0] dow_o,
    output logic [5:0] hour_o,
    output logic [6:0] minute_o,
    output logic [7:0] disp_o
);

    typedef enum logic [0:0] {StHunt, StCollect} state_e;

    state_e      state_q, state_d;
    logic [5:0]  second_q, second_d;
    logic        synced_q, synced_d;
    logic        frame_err_q, frame_err_d;
    logic        time_valid_q, time_valid_d;
    logic [7:0]  year_q, year_d;
    logic [4:0]  month_q, month_d;
    logic [5:0]  day_q, day_d;
    logic [2:0]  dow_q, dow_d;
    logic [5:0]  hour_q, hour_d;
    logic [6:0]  minute_q, minute_d;
    logic [7:0]  disp_q, disp_d;
    // Bit k holds the symbol received k seconds before the newest one, so every
    // field sits at a fixed offset from the end of the frame regardless of leap seconds.
    logic [42:0] a_sr_q, a_sr_d;
    logic [5:0]  b_sr_q, b_sr_d;

    logic len_ok, marker_ok, parity_ok, frame_ok;

    always_comb begin
        len_ok    = (32'(second_q) >= MIN_SEC) && (32'(second_q) <= MAX_SEC);
        marker_ok = !MARKER_EN || (a_sr_q[7:0] == 8'b0111_1110);
        parity_ok = !PARITY_EN ||
                    ((^{a_sr_q[42:35], b_sr_q[5]}) && (^{a_sr_q[34:24], b_sr_q[4]}) &&
                     (^{a_sr_q[23:21], b_sr_q[3]}) && (^{a_sr_q[20:8], b_sr_q[2]}));
        frame_ok  = len_ok && marker_ok && parity_ok;
    end

    always_comb begin
        state_d      = state_q;
        second_d     = second_q;
        synced_d     = synced_q;
        frame_err_d  = frame_err_q;
        time_valid_d = 1'b0;
        year_d       = year_q;
        month_d      = month_q;
        day_d        = day_q;
        dow_d        = dow_q;
        hour_d       = hour_q;
        minute_d     = minute_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;

        if (bits_valid_i) begin
            a_sr_d = {a_sr_q[41:0], bits_data_i[1]};
            b_sr_d = {b_sr_q[4:0], bits_data_i[0]};
            case (state_q)
                StHunt: begin
                    if (bits_is_second_00_i) begin
                        state_d  = StCollect;
                        second_d = 6'd0;
                    end
                end
                StCollect: begin
                    if (!bits_is_second_00_i) begin
                        if (32'(second_q) >= MAX_SEC) begin
                            state_d     = StHunt;
                            frame_err_d = 1'b1;
                            synced_d    = 1'b0;
                            second_d    = 6'd0;
                        end else begin
                            second_d = second_q + 6'd1;
                        end
                    end else begin
                        // Frame is judged on the shift registers before this marker shifts in.
                        second_d = 6'd0;
                        if (frame_ok) begin
                            year_d       = a_sr_q[42:35];
                            month_d      = a_sr_q[34:30];
                            day_d        = a_sr_q[29:24];
                            dow_d        = a_sr_q[23:21];
                            hour_d       = a_sr_q[20:15];
                            minute_d     = a_sr_q[14:8];
                            time_valid_d = 1'b1;
                            synced_d     = 1'b1;
                            frame_err_d  = 1'b0;
                        end else begin
                            frame_err_d = 1'b1;
                            synced_d    = 1'b0;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        case (disp_sel_i)
            3'd0:    disp_d = {1'b0, minute_q};
            3'd1:    disp_d = {2'b0, hour_q};
            3'd2:    disp_d = {2'b0, day_q};
            3'd3:    disp_d = {3'b0, month_q};
            3'd4:    disp_d = year_q;
            3'd5:    disp_d = {5'b0, dow_q};
            3'd6:    disp_d = {synced_q, frame_err_q, second_q};
            default: disp_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StHunt;
            second_q     <= '0;
            synced_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            time_valid_q <= 1'b0;
            year_q       <= '0;
            month_q      <= '0;
            day_q        <= '0;
            dow_q        <= '0;
            hour_q       <= '0;
            minute_q     <= '0;
            disp_q       <= '0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
        end else begin
            state_q      <= state_d;
            second_q     <= second_d;
            synced_q     <= synced_d;
            frame_err_q  <= frame_err_d;
            time_valid_q <= time_valid_d;
            year_q       <= year_d;
            month_q      <= month_d;
            day_q        <= day_d;
            dow_q        <= dow_d;
            hour_q       <= hour_d;
            minute_q     <= minute_d;
            disp_q       <= disp_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
        end
    end

    assign time_valid_o = time_valid_q;
    assign synced_o     = synced_q;
    assign frame_err_o  = frame_err_q;
    assign second_o     = second_q;
    assign year_o       = year_q;
    assign month_o      = month_q;
    assign day_o        = day_q;
    assign dow_o        = dow_q;
    assign hour_o       = hour_q;
    assign minute_o     = minute_q;
    assign disp_o       = disp_q;

endmodule

// File: tb/tb_msf_frame_assembler.sv
// Randomised bench for msf_frame_assembler: two instances (parity check on/off) share
// stimulus and are compared every cycle against a frame-array reference model.
module tb_msf_frame_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, bits_valid, is00;
    logic [1:0] data;
    logic [2:0] sel;

    logic       tv     [2];
    logic       synced [2];
    logic       ferr   [2];
    logic [5:0] sec    [2];
    logic [7:0] year   [2];
    logic [4:0] month  [2];
    logic [5:0] day    [2];
    logic [2:0] dow    [2];
    logic [5:0] hour   [2];
    logic [6:0] minute [2];
    logic [7:0] disp   [2];

    msf_frame_assembler u_dut (
        .clk_i(clk), .rst_i(rst), .bits_valid_i(bits_valid), .bits_is_second_00_i(is00),
        .bits_data_i(data), .disp_sel_i(sel), .time_valid_o(tv[0]), .synced_o(synced[0]),
        .frame_err_o(ferr[0]), .second_o(sec[0]), .year_o(year[0]), .month_o(month[0]),
        .day_o(day[0]), .dow_o(dow[0]), .hour_o(hour[0]), .minute_o(minute[0]), .disp_o(disp[0])
    );

    msf_frame_assembler #(.PARITY_EN(1'b0)) u_dut_np (
        .clk_i(clk), .rst_i(rst), .bits_valid_i(bits_valid), .bits_is_second_00_i(is00),
        .bits_data_i(data), .disp_sel_i(sel), .time_valid_o(tv[1]), .synced_o(synced[1]),
        .frame_err_o(ferr[1]), .second_o(sec[1]), .year_o(year[1]), .month_o(month[1]),
        .day_o(day[1]), .dow_o(dow[1]), .hour_o(hour[1]), .minute_o(minute[1]), .disp_o(disp[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one copy per instance (index 1 has parity disabled).
    bit m_hunt [2];
    int m_sec [2];
    bit m_sync [2], m_err [2], m_tv [2];
    int m_year [2], m_month [2], m_day [2], m_dow [2], m_hour [2], m_min [2];
    int exp_disp [2];
    bit fr_a [2][64];
    bit fr_b [2][64];

    // Frame under construction, by absolute second index.
    bit fa [64];
    bit fb [64];
    int cur_fin;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int field(input int k, input int start, input int len);
        int v = 0;
        for (int j = 0; j < len; j++) v = v * 2 + int'(fr_a[k][start + j]);
        return v;
    endfunction

    function automatic bit group_odd(input int k, input int s, input int e, input int bpos);
        int c = int'(fr_b[k][bpos]);
        for (int i = s; i <= e; i++) c += int'(fr_a[k][i]);
        return (c % 2) == 1;
    endfunction

    function automatic bit frame_good(input int k, input int fin);
        int off = fin - 59;
        if (fin < 58 || fin > 60) return 1'b0;
        if (fr_a[k][fin - 7] != 1'b0 || fr_a[k][fin] != 1'b0) return 1'b0;
        for (int i = fin - 6; i <= fin - 1; i++) if (fr_a[k][i] != 1'b1) return 1'b0;
        if (k == 0) begin
            if (!group_odd(k, 17 + off, 24 + off, 54 + off)) return 1'b0;
            if (!group_odd(k, 25 + off, 35 + off, 55 + off)) return 1'b0;
            if (!group_odd(k, 36 + off, 38 + off, 56 + off)) return 1'b0;
            if (!group_odd(k, 39 + off, 51 + off, 57 + off)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input int k, input bit s00, input bit a, input bit b);
        int fin, off;
        m_tv[k] = 1'b0;
        if (m_hunt[k]) begin
            if (s00) begin
                m_hunt[k] = 1'b0; m_sec[k] = 0; fr_a[k][0] = a; fr_b[k][0] = b;
            end
        end else if (!s00) begin
            if (m_sec[k] + 1 > 60) begin
                m_hunt[k] = 1'b1; m_err[k] = 1'b1; m_sync[k] = 1'b0; m_sec[k] = 0;
            end else begin
                m_sec[k]++; fr_a[k][m_sec[k]] = a; fr_b[k][m_sec[k]] = b;
            end
        end else begin
            fin = m_sec[k];
            off = fin - 59;
            if (frame_good(k, fin)) begin
                m_year[k] = field(k, 17 + off, 8); m_month[k] = field(k, 25 + off, 5);
                m_day[k]  = field(k, 30 + off, 6); m_dow[k]   = field(k, 36 + off, 3);
                m_hour[k] = field(k, 39 + off, 6); m_min[k]   = field(k, 45 + off, 7);
                m_tv[k] = 1'b1; m_sync[k] = 1'b1; m_err[k] = 1'b0;
            end else begin
                m_err[k] = 1'b1; m_sync[k] = 1'b0;
            end
            m_sec[k] = 0; fr_a[k][0] = a; fr_b[k][0] = b;
        end
    endtask

    function automatic int disp_fn(input int k, input int s);
        case (s)
            0: return m_min[k];
            1: return m_hour[k];
            2: return m_day[k];
            3: return m_month[k];
            4: return m_year[k];
            5: return m_dow[k];
            6: return int'(m_sync[k]) * 128 + int'(m_err[k]) * 64 + m_sec[k];
            default: return 0;
        endcase
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("u%0d.time_valid", k), 32'(tv[k]), 32'(m_tv[k]));
            check_val($sformatf("u%0d.synced", k), 32'(synced[k]), 32'(m_sync[k]));
            check_val($sformatf("u%0d.frame_err", k), 32'(ferr[k]), 32'(m_err[k]));
            check_val($sformatf("u%0d.second", k), 32'(sec[k]), m_sec[k]);
            check_val($sformatf("u%0d.year", k), 32'(year[k]), m_year[k]);
            check_val($sformatf("u%0d.month", k), 32'(month[k]), m_month[k]);
            check_val($sformatf("u%0d.day", k), 32'(day[k]), m_day[k]);
            check_val($sformatf("u%0d.dow", k), 32'(dow[k]), m_dow[k]);
            check_val($sformatf("u%0d.hour", k), 32'(hour[k]), m_hour[k]);
            check_val($sformatf("u%0d.minute", k), 32'(minute[k]), m_min[k]);
            check_val($sformatf("u%0d.disp", k), 32'(disp[k]), exp_disp[k]);
        end
    endtask

    task automatic step(input bit v, input bit s00, input bit a, input bit b, input int s);
        sel = 3'(s);
        bits_valid = v; is00 = s00; data = {a, b};
        for (int k = 0; k < 2; k++) exp_disp[k] = disp_fn(k, s);
        @(posedge clk);
        #1;
        bits_valid = 1'b0; is00 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_tv[k] = 1'b0;
            if (v) model_step(k, s00, a, b);
        end
        check_all();
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 7));
    endtask

    task automatic sym(input bit s00, input bit a, input bit b);
        gap();
        step(1'b1, s00, a, b, $urandom_range(0, 7));
    endtask

    task automatic do_reset();
        rst = 1'b1; bits_valid = 1'b1; is00 = 1'b1; data = 2'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0; bits_valid = 1'b0; is00 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_hunt[k] = 1'b1; m_sec[k] = 0; m_sync[k] = 1'b0; m_err[k] = 1'b0; m_tv[k] = 1'b0;
            m_year[k] = 0; m_month[k] = 0; m_day[k] = 0; m_dow[k] = 0; m_hour[k] = 0;
            m_min[k] = 0; exp_disp[k] = 0;
        end
        check_all();
    endtask

    task automatic put(input int start, input int len, input logic [7:0] val);
        for (int j = 0; j < len; j++) fa[start + j] = val[len - 1 - j];
    endtask

    function automatic bit xor_a(input int s, input int e);
        bit x = 1'b0;
        for (int i = s; i <= e; i++) x ^= fa[i];
        return x;
    endfunction

    task automatic build(input logic [7:0] yy, input logic [7:0] mo, input logic [7:0] dd,
                         input logic [7:0] dw, input logic [7:0] hh, input logic [7:0] mi,
                         input int fin, input bit flip57, input bit bad55);
        int off = fin - 59;
        cur_fin = fin;
        for (int i = 0; i < 64; i++) begin
            fa[i] = 1'($urandom); fb[i] = 1'($urandom);
        end
        put(17 + off, 8, yy); put(25 + off, 5, mo); put(30 + off, 6, dd);
        put(36 + off, 3, dw); put(39 + off, 6, hh); put(45 + off, 7, mi);
        fa[fin - 7] = 1'b0;
        for (int i = fin - 6; i <= fin - 1; i++) fa[i] = 1'b1;
        fa[fin] = 1'b0;
        fb[54 + off] = ~xor_a(17 + off, 24 + off);
        fb[55 + off] = ~xor_a(25 + off, 35 + off);
        fb[56 + off] = ~xor_a(36 + off, 38 + off);
        fb[57 + off] = ~xor_a(39 + off, 51 + off);
        if (flip57) fb[57 + off] = ~fb[57 + off];
        if (bad55) fa[55 + off] = 1'b0;
    endtask

    function automatic logic [7:0] rbcd(input int hi_max, input int lo_max);
        return 8'($urandom_range(0, hi_max) * 16 + $urandom_range(0, lo_max));
    endfunction

    task automatic build_rand(input int fin, input bit flip57, input bit bad55);
        build(rbcd(9, 9), rbcd(1, 9) & 8'h1f, rbcd(3, 9) & 8'h3f, 8'($urandom_range(0, 6)),
              rbcd(2, 9) & 8'h3f, rbcd(5, 9) & 8'h7f, fin, flip57, bad55);
    endtask

    task automatic send_mark();
        sym(1'b1, fa[0], fb[0]);
    endtask

    task automatic send_body();
        for (int i = 1; i <= cur_fin; i++) sym(1'b0, fa[i], fb[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; bits_valid = 1'b0; is00 = 1'b0; data = 2'b00; sel = 3'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Non-marker symbols in HUNT are ignored.
        repeat (5) sym(1'b0, 1'($urandom), 1'($urandom));

        build(8'h23, 8'h06, 8'h15, 8'h04, 8'h12, 8'h34, 59, 1'b0, 1'b0);
        send_mark();
        send_body();

        // Same date with 57B flipped; its marker commits the first frame.
        build(8'h23, 8'h06, 8'h15, 8'h04, 8'h12, 8'h34, 59, 1'b1, 1'b0);
        send_mark();
        check_val("tp.tv", 32'(tv[0]), 32'd1);
        check_val("tp.year", 32'(year[0]), 32'h23);
        check_val("tp.month", 32'(month[0]), 32'h06);
        check_val("tp.day", 32'(day[0]), 32'h15);
        check_val("tp.dow", 32'(dow[0]), 32'd4);
        check_val("tp.hour", 32'(hour[0]), 32'h12);
        check_val("tp.minute", 32'(minute[0]), 32'h34);
        check_val("tp.synced", 32'(synced[0]), 32'd1);
        send_body();

        build(8'h47, 8'h11, 8'h28, 8'h02, 8'h09, 8'h58, 59, 1'b0, 1'b1);
        send_mark();
        check_val("par.tv", 32'(tv[0]), 32'd0);
        check_val("par.err", 32'(ferr[0]), 32'd1);
        check_val("par.year_hold", 32'(year[0]), 32'h23);
        check_val("nopar.tv", 32'(tv[1]), 32'd1);
        send_body();

        // Leap frames: final 60 and final 58.
        build_rand(60, 1'b0, 1'b0);
        send_mark();
        check_val("mk55.err", 32'(ferr[0]), 32'd1);
        send_body();
        build_rand(58, 1'b0, 1'b0);
        send_mark();
        check_val("leap60.synced", 32'(synced[0]), 32'd1);
        send_body();
        build_rand(59, 1'b0, 1'b0);
        send_mark();
        check_val("leap58.tv", 32'(tv[0]), 32'd1);
        send_body();

        // Overrun: marker followed by 61 non-marker symbols.
        build_rand(59, 1'b0, 1'b0);
        send_mark();
        for (int i = 1; i <= 61; i++) sym(1'b0, 1'($urandom), 1'($urandom));
        check_val("ovr.err", 32'(ferr[0]), 32'd1);
        check_val("ovr.second", 32'(sec[0]), 32'd0);
        repeat (4) sym(1'b0, 1'($urandom), 1'($urandom));

        // Reset at second 30.
        build_rand(59, 1'b0, 1'b0);
        send_mark();
        send_body();
        build_rand(59, 1'b0, 1'b0);
        send_mark();
        for (int i = 1; i <= 30; i++) sym(1'b0, fa[i], fb[i]);
        do_reset();
        repeat (6) sym(1'b0, 1'($urandom), 1'($urandom));
        check_val("rst.second", 32'(sec[0]), 32'd0);

        build_rand(59, 1'b0, 1'b0);
        send_mark();
        send_body();
        for (int f = 0; f < 6; f++) begin
            build_rand($urandom_range(58, 60), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0));
            send_mark();
            send_body();
        end
        build_rand(59, 1'b0, 1'b0);
        send_mark();

        // Display sweep with the bus idle.
        for (int s = 0; s < 8; s++) step(1'b0, 1'b0, 1'b0, 1'b0, s);
        step(1'b0, 1'b0, 1'b0, 1'b0, 7);
        check_val("disp.sel7", 32'(disp[0]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
